dcm_reset_ctrl: RTL and testbench



---
 rtl/dcm_reset_ctrl_pkg.sv | 28 ++
 rtl/sync_signal.sv | 33 +++
 rtl/dcm_reset_ctrl.sv | 158 +++++++++++++++
 tb/tb_dcm_reset_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcm_reset_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dcm_reset_ctrl_pkg
// Brief    : State encodings, DCM status bit positions and helpers shared by
//            the DCM reset sequencer.
// Revision : 1.0
// ============================================================================
package dcm_reset_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_PULSE     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    localparam int STATUS_CLKIN_STOPPED = 1;
    localparam int STATUS_CLKFX_STOPPED = 2;

    localparam int CNT_W = 17;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_signal.sv
`default_nettype none
// ============================================================================
// Module   : sync_signal
// Brief    : N-stage flop synchroniser for a bus of independent async bits.
// Revision : 1.0
// ============================================================================
module sync_signal #(
    parameter int WIDTH = 3,
    parameter int N     = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [N-1:0][WIDTH-1:0] r_stage;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stage <= '0;
        end else begin
            r_stage[0] <= i_async;
            for (int i = 1; i < N; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_sync = r_stage[N-1];

endmodule
`default_nettype wire

// File: rtl/dcm_reset_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dcm_reset_ctrl
// Brief    : DCM_SP reset sequencer: timed reset pulses, lock timeout/retry,
//            lock qualification and downstream system reset release.
// Revision : 1.0
// ============================================================================
module dcm_reset_ctrl
    import dcm_reset_ctrl_pkg::*;
#(
    parameter int RST_PULSE_CYCLES = 3,
    parameter int LOCK_TIMEOUT     = 100000,
    parameter int STABLE_CYCLES    = 1024,
    parameter int MAX_RETRIES      = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       dcm_locked,
    input  logic [7:0] dcm_status,
    input  logic       sw_restart,
    output logic       dcm_rst,
    output logic       sys_rst,
    output logic       lock_ok,
    output logic       fault,
    output logic [7:0] retry_count
);

    localparam logic [CNT_W-1:0] c_pulse_last   = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_stable_last  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_fx_min       = CNT_W'(3);
    localparam logic [7:0]       c_max_retries  = 8'(MAX_RETRIES);

    logic [2:0] w_sync_out;
    logic       w_locked_s;
    logic       w_clkin_stop;
    logic       w_clkfx_stop;
    logic       w_unused_status;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_attempt;
    logic [7:0]       r_retry;
    logic             r_dcm_rst;
    logic             r_sys_rst;
    logic             r_lock_ok;
    logic             r_fault;

    state_t     w_next;
    logic       w_fail;
    logic [7:0] w_attempt_next;
    logic       w_fail_to_fault;
    logic       w_cnt_clear;

    sync_signal #(
        .WIDTH (3),
        .N     (2)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_async ({dcm_status[STATUS_CLKFX_STOPPED],
                   dcm_status[STATUS_CLKIN_STOPPED],
                   dcm_locked}),
        .o_sync  (w_sync_out)
    );

    assign w_locked_s   = w_sync_out[0];
    assign w_clkin_stop = w_sync_out[1];
    assign w_clkfx_stop = w_sync_out[2];

    // Remaining status bits carry no supervision meaning for this sequencer.
    assign w_unused_status = ^{dcm_status[7:3], dcm_status[0]};

    assign w_attempt_next  = sat_inc8(r_attempt);
    assign w_fail_to_fault = (MAX_RETRIES != 0) && (w_attempt_next == c_max_retries);

    always_comb begin
        w_next = r_state;
        w_fail = 1'b0;
        if (sw_restart) begin
            w_next = ST_PULSE;
        end else begin
            case (r_state)
                ST_PULSE: begin
                    if (r_cnt == c_pulse_last) w_next = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    // A stopped CLKFX is only trusted once the DCM has had a few cycles out of reset.
                    if ((!w_locked_s && w_clkfx_stop && (r_cnt >= c_fx_min)) ||
                        (r_cnt == c_timeout_last)) begin
                        w_fail = 1'b1;
                    end else if (w_locked_s) begin
                        w_next = ST_STABLE;
                    end
                end
                ST_STABLE: begin
                    if (!w_locked_s)                   w_fail = 1'b1;
                    else if (r_cnt == c_stable_last)   w_next = ST_RUN;
                end
                ST_RUN: begin
                    if (!w_locked_s || w_clkin_stop || w_clkfx_stop) w_next = ST_PULSE;
                end
                ST_FAULT: begin
                    w_next = ST_FAULT;
                end
                default: begin
                    w_next = ST_PULSE;
                end
            endcase
            if (w_fail) w_next = w_fail_to_fault ? ST_FAULT : ST_PULSE;
        end
    end

    assign w_cnt_clear = sw_restart || (w_next != r_state);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_PULSE;
            r_cnt     <= '0;
            r_attempt <= 8'd0;
            r_retry   <= 8'd0;
            r_dcm_rst <= 1'b1;
            r_sys_rst <= 1'b1;
            r_lock_ok <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state <= w_next;

            if (w_cnt_clear) begin
                r_cnt <= '0;
            end else if (r_state == ST_PULSE || r_state == ST_WAIT_LOCK || r_state == ST_STABLE) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (sw_restart || (w_next == ST_RUN && r_state == ST_STABLE)) begin
                r_attempt <= 8'd0;
            end else if (w_fail) begin
                r_attempt <= w_attempt_next;
            end

            if (w_fail) r_retry <= sat_inc8(r_retry);

            // Outputs are decoded from the next state so they change on the transition edge.
            r_dcm_rst <= (w_next == ST_PULSE) || (w_next == ST_FAULT);
            r_sys_rst <= (w_next != ST_RUN);
            r_lock_ok <= (w_next == ST_RUN);
            r_fault   <= (w_next == ST_FAULT);
        end
    end

    assign dcm_rst     = r_dcm_rst;
    assign sys_rst     = r_sys_rst;
    assign lock_ok     = r_lock_ok;
    assign fault       = r_fault;
    assign retry_count = r_retry;

endmodule
`default_nettype wire

// File: tb/tb_dcm_reset_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcm_reset_ctrl
// Brief    : Scoreboard bench for dcm_reset_ctrl; expected output-change events
//            are derived from the sequencing timing rules.
// Revision : 1.0
// ============================================================================
module tb_dcm_reset_ctrl;

    localparam int P   = 3;
    localparam int T   = 20;
    localparam int STB = 8;
    localparam int MR  = 2;

    logic       clk        = 1'b0;
    logic       reset_n    = 1'b0;
    logic       dcm_locked = 1'b0;
    logic [7:0] dcm_status = 8'd0;
    logic       sw_restart = 1'b0;
    logic       dcm_rst;
    logic       sys_rst;
    logic       lock_ok;
    logic       fault;
    logic [7:0] retry_count;

    dcm_reset_ctrl #(
        .RST_PULSE_CYCLES (P),
        .LOCK_TIMEOUT     (T),
        .STABLE_CYCLES    (STB),
        .MAX_RETRIES      (MR)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .dcm_locked  (dcm_locked),
        .dcm_status  (dcm_status),
        .sw_restart  (sw_restart),
        .dcm_rst     (dcm_rst),
        .sys_rst     (sys_rst),
        .lock_ok     (lock_ok),
        .fault       (fault),
        .retry_count (retry_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          edge_n;
        logic [11:0] outs;
    } ev_t;

    ev_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          m_retry = 0;
    int          m_attempt = 0;
    bit          mon_en = 1'b0;
    logic [11:0] prev_outs;
    wire  [11:0] dut_outs = {dcm_rst, sys_rst, lock_ok, fault, retry_count};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [11:0] mk(input bit d, input bit s, input bit l, input bit f);
        return {d, s, l, f, 8'(m_retry)};
    endfunction

    task automatic expect_at(input int e, input bit d, input bit s, input bit l, input bit f);
        exp_q.push_back('{edge_n: e, outs: mk(d, s, l, f)});
    endtask

    // Failed attempt at edge e: counters advance, then PULSE or FAULT.
    task automatic fail_at(input int e);
        bit to_fault;
        m_attempt++;
        if (m_retry < 255) m_retry++;
        to_fault = (MR != 0) && (m_attempt == MR);
        expect_at(e, 1'b1, 1'b1, 1'b0, to_fault);
    endtask

    // Monitor: every change on the outputs must match the next expected event.
    always @(negedge clk) begin : monitor
        ev_t e;
        if (mon_en && (dut_outs !== prev_outs)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_change: cycle %0d got %03h expected no change", cyc, dut_outs);
            end else begin
                e = exp_q.pop_front();
                check("event_cycle", cyc, e.edge_n);
                check("event_outputs", {20'd0, dut_outs}, {20'd0, e.outs});
            end
            prev_outs = dut_outs;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int e);
        while (cyc < e) step();
    endtask

    // Lock qualification: STABLE starts when WAIT_LOCK sees the synchronised lock.
    task automatic reach_run(input int w, input int l);
        int s;
        s = (l + 3 > w + 1) ? l + 3 : w + 1;
        expect_at(s + STB, 1'b0, 1'b0, 1'b1, 1'b0);
        m_attempt = 0;
        wait_until(s + STB + 2);
        check("retry_in_run", {24'd0, retry_count}, 32'(m_retry));
        check("lock_ok_in_run", {31'd0, lock_ok}, 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int  r, w, w2, l, d, x, k, j, dur, src;
        logic [7:0] noise;

        // Reset values
        step();
        check("reset_dcm_rst", {31'd0, dcm_rst}, 32'd1);
        check("reset_sys_rst", {31'd0, sys_rst}, 32'd1);
        check("reset_lock_ok", {31'd0, lock_ok}, 32'd0);
        check("reset_fault", {31'd0, fault}, 32'd0);
        check("reset_retry", {24'd0, retry_count}, 32'd0);
        prev_outs = 12'b1100_0000_0000;
        mon_en = 1'b1;
        step();

        // First lock, raised 5 cycles after dcm_rst falls
        r = cyc;
        reset_n = 1'b1;
        w = r + P;
        expect_at(w, 1'b0, 1'b1, 1'b0, 1'b0);
        l = w + 5;
        wait_until(l);
        dcm_locked = 1'b1;
        reach_run(w, l);

        // One-cycle lock drop in RUN
        x = cyc;
        dcm_locked = 1'b0;
        expect_at(x + 3, 1'b1, 1'b1, 1'b0, 1'b0);
        w = x + 3 + P;
        expect_at(w, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        dcm_locked = 1'b1;
        reach_run(w, x + 1);

        // Lock lost for good: two timeouts lead to FAULT
        x = cyc;
        dcm_locked = 1'b0;
        expect_at(x + 3, 1'b1, 1'b1, 1'b0, 1'b0);
        w = x + 3 + P;
        expect_at(w, 1'b0, 1'b1, 1'b0, 1'b0);
        fail_at(w + T);
        w2 = w + T + P;
        expect_at(w2, 1'b0, 1'b1, 1'b0, 1'b0);
        fail_at(w2 + T);
        wait_until(w2 + T + 6);
        check("fault_outputs", {29'd0, fault, dcm_rst, sys_rst}, 32'b111);
        check("fault_retry", {24'd0, retry_count}, 32'(m_retry));

        // sw_restart out of FAULT, then lock after a random delay
        x = cyc;
        m_attempt = 0;
        expect_at(x + 1, 1'b1, 1'b1, 1'b0, 1'b0);
        sw_restart = 1'b1;
        step();
        sw_restart = 1'b0;
        w = x + 1 + P;
        expect_at(w, 1'b0, 1'b1, 1'b0, 1'b0);
        d = $urandom_range(T - 6, 1);
        wait_until(w + d);
        dcm_locked = 1'b1;
        reach_run(w, w + d);

        // Lock drop during STABLE is a failed attempt
        x = cyc;
        dcm_locked = 1'b0;
        expect_at(x + 3, 1'b1, 1'b1, 1'b0, 1'b0);
        w = x + 3 + P;
        expect_at(w, 1'b0, 1'b1, 1'b0, 1'b0);
        d = $urandom_range(8, 1);
        k = $urandom_range(4, 0);
        wait_until(w + d);
        dcm_locked = 1'b1;
        wait_until(w + d + 3 + k);
        dcm_locked = 1'b0;
        fail_at(w + d + 6 + k);
        w2 = w + d + 6 + k + P;
        expect_at(w2, 1'b0, 1'b1, 1'b0, 1'b0);
        d = $urandom_range(8, 1);
        wait_until(w2 + d);
        dcm_locked = 1'b1;
        reach_run(w2, w2 + d);

        // CLKFX stopped while waiting for lock fails after 4 cycles
        x = cyc;
        dcm_locked = 1'b0;
        dcm_status = 8'h04;
        expect_at(x + 3, 1'b1, 1'b1, 1'b0, 1'b0);
        w = x + 3 + P;
        expect_at(w, 1'b0, 1'b1, 1'b0, 1'b0);
        fail_at(w + 4);
        w2 = w + 4 + P;
        expect_at(w2, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_until(w + 4);
        dcm_status = 8'h00;
        d = $urandom_range(8, 1);
        wait_until(w2 + d);
        dcm_locked = 1'b1;
        reach_run(w2, w2 + d);

        // Random short disturbances in RUN with noise on unused status bits
        for (int it = 0; it < 6; it++) begin
            src   = $urandom_range(2, 0);
            dur   = $urandom_range(3, 1);
            noise = 8'($urandom) & 8'hF9;
            dcm_status = noise;
            step();
            x = cyc;
            case (src)
                0:       dcm_locked = 1'b0;
                1:       dcm_status = noise | 8'h02;
                default: dcm_status = noise | 8'h04;
            endcase
            expect_at(x + 3, 1'b1, 1'b1, 1'b0, 1'b0);
            w = x + 3 + P;
            expect_at(w, 1'b0, 1'b1, 1'b0, 1'b0);
            wait_until(x + dur);
            dcm_locked = 1'b1;
            dcm_status = noise;
            reach_run(w, x + dur);
        end
        dcm_status = 8'h00;

        // reset_n asserted in the middle of WAIT_LOCK
        x = cyc;
        dcm_locked = 1'b0;
        expect_at(x + 3, 1'b1, 1'b1, 1'b0, 1'b0);
        w = x + 3 + P;
        expect_at(w, 1'b0, 1'b1, 1'b0, 1'b0);
        j = $urandom_range(T - 3, 1);
        wait_until(w + j);
        m_retry = 0;
        m_attempt = 0;
        expect_at(w + j, 1'b1, 1'b1, 1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs", {20'd0, dut_outs}, {20'd0, mk(1'b1, 1'b1, 1'b0, 1'b0)});
        step();
        step();
        r = cyc;
        reset_n = 1'b1;
        w = r + P;
        expect_at(w, 1'b0, 1'b1, 1'b0, 1'b0);

        // sw_restart on the same cycle the timeout would fire
        wait_until(w + T - 1);
        expect_at(w + T, 1'b1, 1'b1, 1'b0, 1'b0);
        m_attempt = 0;
        sw_restart = 1'b1;
        step();
        sw_restart = 1'b0;
        w2 = w + T + P;
        expect_at(w2, 1'b0, 1'b1, 1'b0, 1'b0);
        fail_at(w2 + T);
        w = w2 + T + P;
        expect_at(w, 1'b0, 1'b1, 1'b0, 1'b0);
        d = $urandom_range(8, 1);
        wait_until(w + d);
        dcm_locked = 1'b1;
        reach_run(w, w + d);

        wait_until(cyc + 5);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
